mmr_trigger_scheduler: RTL
==========================

MMR_TRIGGER_SCHEDULER -- requirements
Module: mmr_trigger_scheduler

Interface
REQ-001 Parameter WIDTH, default 8: number of trigger bits; legal range 1..32.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum RUN duration in cycles; 0 disables the timeout.
REQ-003 Localparam IDW = max(1, $clog2(WIDTH)): width of job_id.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  scheduler enable; bit 0 of the control register.
REQ-007 tsr  in  WIDTH  pending trigger status bits, as held by the MMR block.
REQ-008 tsr_invpulses  out  WIDTH  one-cycle clear pulse for the accepted trigger bit.
REQ-009 isr_pulses  out  WIDTH  one-cycle completion pulse, ORed into ISR by the MMR block.
REQ-010 timeout_pulse  out  1  one-cycle pulse when a job exceeds TIMEOUT_CYCLES.
REQ-011 job_valid  out  1  job offer to the processor.
REQ-012 job_ready  in  1  processor accepts the offered job.
REQ-013 job_id  out  IDW  index of the offered or running trigger.
REQ-014 job_done  in  1  processor reports that the running job has finished.
REQ-015 busy  out  1  high in the ISSUE and RUN states.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RUN.
REQ-017 IDLE: if enable=1 and tsr!=0, the block SHALL select a bit by round-robin and move to ISSUE; otherwise it stays in IDLE.
REQ-018 Round-robin search SHALL start at (last_grant+1) mod WIDTH, wrap past WIDTH-1 to 0, and pick the first set bit.
REQ-019 last_grant SHALL update to the selected index on each selection.
REQ-020 Timing: tsr is sampled set at edge t, so job_valid=1 and job_id are valid from edge t+1.
REQ-021 ISSUE: job_valid and job_id SHALL stay stable until job_valid&&job_ready, even if enable falls or tsr changes.
REQ-022 On a handshake at edge h, tsr_invpulses[job_id] SHALL be 1 for exactly the cycle after h, job_valid SHALL drop, and the state SHALL become RUN.
REQ-023 RUN: job_id SHALL be held, and a cycle counter SHALL clear on RUN entry and increment every RUN cycle.
REQ-024 job_done=1 in RUN SHALL set isr_pulses[job_id]=1 for the next cycle and return the FSM to IDLE.
REQ-025 With TIMEOUT_CYCLES>0, if the counter reaches TIMEOUT_CYCLES-1 while job_done=0, the block SHALL set timeout_pulse=1 for the next cycle, leave isr_pulses at 0, and return to IDLE.
REQ-026 When job_done and the timeout coincide, job_done SHALL take priority and timeout_pulse SHALL stay 0.
REQ-027 job_done SHALL be ignored in IDLE and ISSUE, and job_ready SHALL be ignored outside ISSUE.
REQ-028 IDLE entered with a pending tsr bit SHALL select on that same edge, giving back-to-back jobs.
REQ-029 A trigger bit re-set by the host during RUN SHALL be scheduled again later by round-robin, with no special handling.
REQ-030 At most one bit of tsr_invpulses and at most one bit of isr_pulses SHALL be high in any cycle.
REQ-031 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL NOT wrap.

Reset
REQ-032 With reset_n=0, regardless of clock, the state SHALL be IDLE and last_grant SHALL be WIDTH-1, so the first search starts at bit 0.
REQ-033 Reset SHALL clear the counter and force job_valid=0, job_id=0, busy=0, tsr_invpulses=0, isr_pulses=0 and timeout_pulse=0.
REQ-034 Reset during ISSUE or RUN SHALL abandon the job without a clear or completion pulse; the tsr bit stays pending in the MMR block.

Verification
REQ-035 Scenario: WIDTH=8, enable=1, tsr=8'h05, job_ready=1 -> job_id=0 first; next job after job_done is job_id=2; each emits one tsr_invpulses and one isr_pulses bit.
REQ-036 Scenario: tsr=8'h81 with last_grant=7 -> job_id=0, then 7, then 0 (wrap and fairness).
REQ-037 Scenario: job_ready held 0 for 5 cycles while enable drops -> job_valid and job_id stay stable, and the handshake on cycle 6 still completes.
REQ-038 Scenario: TIMEOUT_CYCLES=4, no job_done -> timeout_pulse is high exactly 4 cycles after RUN entry, with isr_pulses=0.
REQ-039 Scenario: job_done and timeout in the same cycle -> isr_pulses set, timeout_pulse=0.
REQ-040 Scenario: reset_n asserted mid-RUN -> all outputs 0 immediately (asynchronously), and after release the first search starts at bit 0.

Source files
------------

// File: rtl/mmr_trigger_scheduler.sv
// Round-robin trigger scheduler: picks a pending tsr bit, offers it as a job, tracks it to completion or timeout.
// Latency: tsr sampled at edge t gives job_valid from t+1; clear/completion/timeout pulses last one cycle after their event.
// Backpressure: the job offer holds stable until job_ready; no new selection while a job is offered or running.
module mmr_trigger_scheduler #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic [WIDTH-1:0]                       tsr,
  output logic [WIDTH-1:0]                       tsr_invpulses,
  output logic [WIDTH-1:0]                       isr_pulses,
  output logic                                   timeout_pulse,
  output logic                                   job_valid,
  input  logic                                   job_ready,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] job_id,
  input  logic                                   job_done,
  output logic                                   busy
);

  localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates when the timeout is disabled.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] LAST_RST = IDW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [IDW-1:0]   last_grant, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] inv_q, inv_d;
  logic [WIDTH-1:0] isr_q, isr_d;
  logic             to_q, to_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  int               rr_cand;

  // Round-robin search: first set tsr bit starting just after the last grant, wrapping at WIDTH-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_cand    = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      rr_cand = int'(last_grant) + i;
      if (rr_cand >= WIDTH) begin
        rr_cand = rr_cand - WIDTH;
      end
      if (!pick_found && tsr[IDW'(rr_cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(rr_cand);
      end
    end
  end

  // Next-state and registered-output logic; pulses default to zero every cycle.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    id_d         = id_q;
    cnt_d        = cnt;
    inv_d        = '0;
    isr_d        = '0;
    to_d         = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pick_found) begin
          state_d      = ISSUE;
          id_d         = pick_idx;
          last_grant_d = pick_idx;
        end
      end
      ISSUE: begin
        if (job_ready) begin
          state_d = RUN;
          inv_d   = WIDTH'(1) << id_q;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (job_done) begin
          // Completion wins over a coincident timeout.
          state_d = IDLE;
          isr_d   = WIDTH'(1) << id_q;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST)) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any job without emitting pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= LAST_RST;
      id_q       <= '0;
      cnt        <= '0;
      inv_q      <= '0;
      isr_q      <= '0;
      to_q       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      id_q       <= id_d;
      cnt        <= cnt_d;
      inv_q      <= inv_d;
      isr_q      <= isr_d;
      to_q       <= to_d;
    end
  end

  assign tsr_invpulses = inv_q;
  assign isr_pulses    = isr_q;
  assign timeout_pulse = to_q;
  assign job_valid     = (state == ISSUE);
  assign job_id        = id_q;
  assign busy          = (state != IDLE);

endmodule
